serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
Oversampling asynchronous serial receiver for the board-to-board GPIO link. It recovers frames from the serial line driven by the far board's transmitter and presents each byte as parallel data with a level-held ready flag. A polling Nios PIO reads the data and acknowledges it, and the block reports framing, overrun and (optionally) parity faults.

Parameters:
DATA_BITS, 8, payload bits per frame, sent LSB first
OVERSAMPLE, 16, sample_tick pulses per bit period; even, >=4

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x bit rate; all bit timing counts these pulses only
data_in  input  1  raw serial line, idles high; asynchronous to clk
char_ack  input  1  one-clk pulse from the consumer; clears char_received and overrun
data_out  output  DATA_BITS  last received payload
char_received  output  1  high from frame completion until char_ack
frame_error  output  1  last frame had a low stop bit; updated at each completion
overrun  output  1  sticky; a frame completed while char_received was still high
parity_error  output  1  last frame failed the even-parity check (see PARITY_EN)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; shift register 0; state IDLE; synchronizer flops preset to 1, which is line idle.
- data_in passes through a 2-flop synchronizer into rx_s. prev_s holds rx_s as of the previous sample_tick. All detection uses rx_s and only on sample_tick cycles.
- IDLE: on a tick where prev_s=1 and rx_s=0, go to START, tick_cnt=0. A line stuck low never re-triggers; a 1 must be seen first.
- START: count ticks. At tick_cnt=OVERSAMPLE/2-1 (mid start bit), if rx_s=0 go to DATA, tick_cnt=0, bit_cnt=0. Otherwise it is a glitch: go to IDLE with no output change.
- DATA: sample rx_s at tick_cnt=OVERSAMPLE-1 and shift it in at the MSB end, so after DATA_BITS shifts the first bit is at bit 0. Reset tick_cnt. After bit_cnt reaches DATA_BITS-1, go to PARITY (macro on) or STOP (macro off).
- PARITY (macro only): sample once at OVERSAMPLE-1 ticks, then go to STOP.
- STOP: sample at OVERSAMPLE-1 ticks, then complete in that same clk:
  - data_out <= shift register
  - frame_error <= ~rx_s
  - parity_error updated
  - char_received <= 1
  - overrun <= overrun | (char_received & ~char_ack)
  - state <= IDLE
- Frames with frame_error are still delivered; the consumer decides whether to discard them.
- Latency: outputs are visible the clk after the stop-bit sampling tick.
- char_ack with no completion in the same cycle: char_received <= 0, overrun <= 0. char_ack while char_received=0 has no effect.
- Completion and char_ack in the same cycle: the new frame wins. char_received stays 1 and overrun is not set; the ack consumed the old frame.
- Overrun: data_out is overwritten with the new frame, and the old frame is lost.
- Back-to-back frames: a stop bit sampled high leaves prev_s=1, so the next start edge is caught with no idle gap needed.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS) bits. Neither counter wraps inside a state.

Optional Feature:
SERIAL_RX_PARITY_EN
- Defined: the frame is start + DATA_BITS + one even-parity bit + stop. At completion, parity_error <= XOR(payload, parity bit).
- Undefined: no PARITY state, the frame is start + DATA_BITS + stop, and parity_error is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Bench setup for all cases: OVERSAMPLE=4, DATA_BITS=8, sample_tick every clk, macro off unless stated.
1. Reset with data_in=1, then send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 40 ticks -> data_out=0xA5, char_received=1, frame_error=0, busy=0; char_ack pulse -> char_received=0.
2. Glitch: data_in low for 1 tick only -> START aborts, back to IDLE, busy drops, no change on char_received or data_out.
3. Send 0x3C with stop bit 0 -> data_out=0x3C, frame_error=1, char_received=1. Hold line low 20 ticks -> no new frame. Line high then send 0x01 -> frame_error=0.
4. Send 0x11 then 0x22 back-to-back with no ack -> data_out=0x22, overrun=1. Send 0x33 with char_ack on the completion cycle -> char_received=1, overrun stays 1 (sticky, not re-set). A later lone ack -> overrun=0.
5. reset_n pulsed low mid-DATA of 0xFF -> all outputs 0 immediately. After release, finish the line with highs -> no spurious frame. Then send 0x5A -> received correctly.
6. Macro defined: send 0x07 with parity 1 -> parity_error=0. Send 0x07 with parity 0 -> parity_error=1, data_out=0x07.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Oversampling asynchronous serial receiver: start/data/(parity)/stop framing, level-held ready flag.
// Optional even-parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_frame_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 data_in,
    input  logic                 char_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 char_received,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_next;
    logic                   sync1, rx_s, prev_s;
    logic [TW-1:0]          tick_cnt, tick_next;
    logic [BW-1:0]          bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   shift_en, complete, parity_sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next    = state;
        tick_next     = tick_cnt;
        bit_next      = bit_cnt;
        shift_en      = 1'b0;
        complete      = 1'b0;
        parity_sample = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    // Falling edge only: a line held low must first return high.
                    if (prev_s && !rx_s) begin
                        state_next = START;
                        tick_next  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        shift_en  = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next     = '0;
                        parity_sample = 1'b1;
                        state_next    = STOP;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            prev_s        <= 1'b1;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            data_out      <= '0;
            char_received <= 1'b0;
            frame_error   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sync1    <= data_in;
            rx_s     <= sync1;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            if (sample_tick) prev_s <= rx_s;
            if (shift_en)    shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            // A completion coinciding with an ack keeps the flag set: the ack consumed the old frame.
            if (complete) begin
                data_out      <= shift_reg;
                frame_error   <= ~rx_s;
                char_received <= 1'b1;
                overrun       <= overrun | (char_received & ~char_ack);
            end else if (char_ack && char_received) begin
                char_received <= 1'b0;
                overrun       <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (parity_sample) parity_bit <= rx_s;
            if (complete)      parity_error <= (^shift_reg) ^ parity_bit;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (OVERSAMPLE=4, DATA_BITS=8, tick every clk).
// Parity cases expect a parity error only when SERIAL_RX_PARITY_EN is defined.
module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_tick;
    logic       data_in;
    logic       char_ack;
    logic [7:0] data_out;
    logic       char_received, frame_error, overrun, parity_error, busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

`ifdef SERIAL_RX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    serial_frame_receiver #(.DATA_BITS(8), .OVERSAMPLE(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .data_in      (data_in),
        .char_ack     (char_ack),
        .data_out     (data_out),
        .char_received(char_received),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .parity_error (parity_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef enum {OP_FRAME, OP_FRAME_NOCHK, OP_ACK, OP_GLITCH, OP_LOW, OP_HIGH} op_t;

    typedef struct {
        op_t         op;
        logic [7:0]  data;
        logic        stop;
        logic        flip;      // invert the parity bit sent
        logic        ack_done;  // pulse char_ack on the completion cycle
        int unsigned n;
        logic [7:0]  e_data;
        logic        e_rdy;
        logic        e_ferr;
        logic        e_ovr;
        logic        e_perr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e_data, input logic e_rdy,
                                 input logic e_ferr, input logic e_ovr, input logic e_perr,
                                 input logic e_busy);
        check({tag, ".data_out"},      32'(data_out),      32'(e_data));
        check({tag, ".char_received"}, 32'(char_received), 32'(e_rdy));
        check({tag, ".frame_error"},   32'(frame_error),   32'(e_ferr));
        check({tag, ".overrun"},       32'(overrun),       32'(e_ovr));
        check({tag, ".parity_error"},  32'(parity_error),  32'(e_perr));
        check({tag, ".busy"},          32'(busy),          32'(e_busy));
    endtask

    // Starts and ends on a falling clock edge; completion lands on the next rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            data_in = d[i];
            repeat (4) @(negedge clk);
        end
`ifdef SERIAL_RX_PARITY_EN
        data_in = (^d) ^ flip;
        repeat (4) @(negedge clk);
`else
        if (flip) data_in = stop;
`endif
        data_in = stop;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        case (v.op)
            OP_FRAME, OP_FRAME_NOCHK: begin
                send_frame(v.data, v.stop, v.flip);
                if (v.op == OP_FRAME) begin
                    if (v.ack_done) char_ack = 1'b1;
                    @(negedge clk);
                    char_ack = 1'b0;
                end
            end
            OP_ACK: begin
                char_ack = 1'b1;
                @(negedge clk);
                char_ack = 1'b0;
            end
            OP_GLITCH: begin
                data_in = 1'b0;
                @(negedge clk);
                data_in = 1'b1;
                repeat (8) @(negedge clk);
            end
            OP_LOW: begin
                data_in = 1'b0;
                repeat (v.n) @(negedge clk);
            end
            OP_HIGH: begin
                data_in = 1'b1;
                repeat (v.n) @(negedge clk);
            end
            default: ;
        endcase
        if (v.op != OP_FRAME_NOCHK)
            check_outputs(tag, v.e_data, v.e_rdy, v.e_ferr, v.e_ovr, v.e_perr, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[17];
        vec_t v5a;

        //          op              data   stp flp ack n   e_data e_rdy ferr ovr perr
        vecs[0]  = '{OP_FRAME,       8'hA5, 1, 0, 0, 0,  8'hA5, 1, 0, 0, 0};
        vecs[1]  = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'hA5, 0, 0, 0, 0};
        vecs[2]  = '{OP_GLITCH,      8'h00, 1, 0, 0, 0,  8'hA5, 0, 0, 0, 0};
        vecs[3]  = '{OP_FRAME,       8'h3C, 0, 0, 0, 0,  8'h3C, 1, 1, 0, 0};
        vecs[4]  = '{OP_LOW,         8'h00, 1, 0, 0, 20, 8'h3C, 1, 1, 0, 0};
        vecs[5]  = '{OP_HIGH,        8'h00, 1, 0, 0, 4,  8'h3C, 1, 1, 0, 0};
        vecs[6]  = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'h3C, 0, 1, 0, 0};
        vecs[7]  = '{OP_FRAME,       8'h01, 1, 0, 0, 0,  8'h01, 1, 0, 0, 0};
        vecs[8]  = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'h01, 0, 0, 0, 0};
        vecs[9]  = '{OP_FRAME_NOCHK, 8'h11, 1, 0, 0, 0,  8'h00, 0, 0, 0, 0};
        vecs[10] = '{OP_FRAME,       8'h22, 1, 0, 0, 0,  8'h22, 1, 0, 1, 0};
        vecs[11] = '{OP_FRAME,       8'h33, 1, 0, 1, 0,  8'h33, 1, 0, 1, 0};
        vecs[12] = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'h33, 0, 0, 0, 0};
        vecs[13] = '{OP_FRAME,       8'h07, 1, 0, 0, 0,  8'h07, 1, 0, 0, 0};
        vecs[14] = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'h07, 0, 0, 0, 0};
        vecs[15] = '{OP_FRAME,       8'h07, 1, 1, 0, 0,  8'h07, 1, 0, 0, PAR};
        vecs[16] = '{OP_ACK,         8'h00, 1, 0, 0, 0,  8'h07, 0, 0, 0, PAR};
        v5a      = '{OP_FRAME,       8'h5A, 1, 0, 0, 0,  8'h5A, 1, 0, 0, 0};

        reset_n     = 1'b0;
        sample_tick = 1'b1;
        data_in     = 1'b1;
        char_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset", 8'h00, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

        // Asynchronous reset in the middle of the data bits of 0xFF.
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        data_in = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_frame.busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_outputs("async_reset", 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (48) @(negedge clk);
        check_outputs("after_reset", 8'h00, 0, 0, 0, 0, 0);
        apply_vec(v5a, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
